// File: rtl/bus_master_port_pkg.sv
// Shared definitions for peripheral-bus masters: size encodings, FSM states,
// latched request record and the alignment rule.
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        SIZE_8  = 2'b00,
        SIZE_16 = 2'b01,
        SIZE_32 = 2'b10,
        SIZE_64 = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_e;

    // Request fields held for the whole bus cycle; the bus address lives in its own flop.
    typedef struct packed {
        logic              write;
        size_e             size;
        logic              sgn;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic logic is_misaligned(input size_e sz, input logic [2:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (sz)
            SIZE_16: bad = addr_lo[0];
            SIZE_32: bad = |addr_lo[1:0];
            SIZE_64: bad = |addr_lo[2:0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/bus_master_port_if.sv
// Core-side request/response handshake of a peripheral-bus master.
// master = load/store stage, slave = bus port.
interface bus_master_port_if;

    logic                        req_valid;
    logic                        req_ready;
    logic                        req_write;
    logic [bus_pkg::ADDR_W-1:0]  req_addr;
    logic [1:0]                  req_size;
    logic                        req_signed;
    logic [bus_pkg::DATA_W-1:0]  req_wdata;
    logic                        resp_valid;
    logic                        resp_error;
    logic [bus_pkg::DATA_W-1:0]  resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
        input  req_ready, resp_valid, resp_error, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
        output req_ready, resp_valid, resp_error, resp_rdata
    );

endinterface

// File: rtl/bus_master_port_lane_format.sv
// Right-justified lane formatting: store operand truncated and zero-extended to
// the access size, load data sign- or zero-extended. Purely combinational.
module bus_lane_format
    import bus_pkg::*;
(
    input  size_e              size,
    input  logic               sgn,
    input  logic [DATA_W-1:0]  wdata_in,
    output logic [DATA_W-1:0]  wdata_out,
    input  logic [DATA_W-1:0]  rdata_in,
    output logic [DATA_W-1:0]  rdata_out
);

    always_comb begin
        wdata_out = '0;
        rdata_out = '0;
        case (size)
            SIZE_8: begin
                wdata_out = {56'd0, wdata_in[7:0]};
                rdata_out = {{56{sgn & rdata_in[7]}}, rdata_in[7:0]};
            end
            SIZE_16: begin
                wdata_out = {48'd0, wdata_in[15:0]};
                rdata_out = {{48{sgn & rdata_in[15]}}, rdata_in[15:0]};
            end
            SIZE_32: begin
                wdata_out = {32'd0, wdata_in[31:0]};
                rdata_out = {{32{sgn & rdata_in[31]}}, rdata_in[31:0]};
            end
            default: begin
                // Full-width access: the signed flag has nothing to extend.
                wdata_out = wdata_in;
                rdata_out = rdata_in;
            end
        endcase
    end

endmodule

// File: rtl/bus_master_port.sv
// Timed initiator for the peripheral bus: one request at a time, latency WAIT_CYCLES+3
// from accept to resp_valid (1 for misaligned); req_ready low whenever a cycle is in flight.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 4
) (
    input  logic                clock,
    input  logic                reset,
    bus_master_port_if.slave    core,
    output logic [ADDR_W-1:0]   address,
    output logic [1:0]          size,
    output logic                mem_read,
    output logic                mem_write,
    inout  wire  [DATA_W-1:0]   data
);

    state_e              state_q, state_d;
    req_t                req_q, req_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    size_e               size_q, size_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                accept;
    logic                drive_en;
    logic [DATA_W-1:0]   wdata_fmt;
    logic [DATA_W-1:0]   rdata_fmt;

    bus_lane_format u_fmt (
        .size      (req_q.size),
        .sgn       (req_q.sgn),
        .wdata_in  (req_q.wdata),
        .wdata_out (wdata_fmt),
        .rdata_in  (data),
        .rdata_out (rdata_fmt)
    );

    assign accept = core.req_valid && (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        address_d = address_q;
        size_d    = size_q;
        rdata_d   = rdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d.write = core.req_write;
                    req_d.size  = size_e'(core.req_size);
                    req_d.sgn   = core.req_signed;
                    req_d.wdata = core.req_wdata;
                    // A rejected request never reaches the pins, so the bus keeps its last address.
                    if (is_misaligned(size_e'(core.req_size), core.req_addr[2:0])) begin
                        state_d = ERR;
                    end else begin
                        state_d   = SETUP;
                        address_d = core.req_addr;
                        size_d    = size_e'(core.req_size);
                    end
                end
            end
            SETUP: begin
                cnt_d   = CNT_W'(WAIT_CYCLES);
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    // The responder has had the whole strobe window; take what it shows now.
                    if (!req_q.write) begin
                        rdata_d = rdata_fmt;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            cnt_q     <= '0;
            address_q <= '0;
            size_q    <= SIZE_8;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            address_q <= address_d;
            size_q    <= size_d;
            rdata_q   <= rdata_d;
        end
    end

    // Strobes decode straight from the state flop so a reset drops them without a clock.
    assign mem_read  = (state_q == STROBE) && !req_q.write;
    assign mem_write = (state_q == STROBE) &&  req_q.write;
    assign drive_en  = mem_write;
    assign data      = drive_en ? wdata_fmt : {DATA_W{1'bz}};

    assign address   = address_q;
    assign size      = size_q;

    assign core.req_ready  = (state_q == IDLE);
    assign core.resp_valid = (state_q == DONE) || (state_q == ERR);
    assign core.resp_error = (state_q == ERR);
    assign core.resp_rdata = rdata_q;

endmodule
